// File: rtl/scrambler_64b66b.sv
// 64b/66b transmit scrambler, G(x) = 1 + x^39 + x^58, payload only.
// Ports: clk, reset (sync, active-high); s_axis_* in; m_axis_* out.
// Param SEED: non-zero scrambler state loaded on reset.
// Option: define SCRAMBLER_BYPASS_EN to add the cfg_bypass input
//   (1 = pass payload unscrambled and freeze the state).
// A registered-ready skid buffer decouples s_axis_tready from m_axis_tready.
module scrambler_64b66b #(
  parameter logic [57:0] SEED = 58'h3FF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
`ifdef SCRAMBLER_BYPASS_EN
  input  logic        cfg_bypass,
`endif
  input  logic [1:0]  s_axis_ttype,
  input  logic [63:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [1:0]  m_axis_ttype,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready
);

  // x[57:0] is the prior history (x[57] newest), x[58+i] is S[i];
  // each output bit taps the bits 39 and 58 positions back.
  function automatic logic [63:0] scramble(
    input logic [57:0] st,
    input logic [63:0] d
  );
    logic [121:0] x;
    x = {64'b0, st};
    for (int i = 0; i < 64; i++) begin
      x[58+i] = d[i] ^ x[i+19] ^ x[i];
    end
    return x[121:58];
  endfunction

  logic [57:0] state_q, state_d;
  logic        out_vld_q, out_vld_d;
  logic [1:0]  out_typ_q, out_typ_d;
  logic [63:0] out_dat_q, out_dat_d;
  logic        skd_vld_q, skd_vld_d;
  logic [1:0]  skd_typ_q, skd_typ_d;
  logic [63:0] skd_dat_q, skd_dat_d;
  logic        rdy_q, rdy_d;

  logic        byp;
  logic        s_hs;
  logic        out_free;
  logic [63:0] scr;
  logic [63:0] new_dat;

  always_comb begin
`ifdef SCRAMBLER_BYPASS_EN
    byp = cfg_bypass;
`else
    byp = 1'b0;
`endif
    scr      = scramble(state_q, s_axis_tdata);
    new_dat  = byp ? s_axis_tdata : scr;
    s_hs     = s_axis_tvalid && rdy_q;
    out_free = !out_vld_q || m_axis_tready;

    state_d   = state_q;
    out_vld_d = out_vld_q;
    out_typ_d = out_typ_q;
    out_dat_d = out_dat_q;
    skd_vld_d = skd_vld_q;
    skd_typ_d = skd_typ_q;
    skd_dat_d = skd_dat_q;

    if (s_hs && !byp) begin
      state_d = scr[63:6];
    end

    if (out_free) begin
      // Skid can only be full while ready is low, so no new
      // word competes with it for the output register.
      if (skd_vld_q) begin
        out_vld_d = 1'b1;
        out_typ_d = skd_typ_q;
        out_dat_d = skd_dat_q;
        skd_vld_d = 1'b0;
      end else if (s_hs) begin
        out_vld_d = 1'b1;
        out_typ_d = s_axis_ttype;
        out_dat_d = new_dat;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (s_hs) begin
      skd_vld_d = 1'b1;
      skd_typ_d = s_axis_ttype;
      skd_dat_d = new_dat;
    end

    rdy_d = !skd_vld_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SEED;
      out_vld_q <= 1'b0;
      out_typ_q <= 2'b0;
      out_dat_q <= 64'b0;
      skd_vld_q <= 1'b0;
      skd_typ_q <= 2'b0;
      skd_dat_q <= 64'b0;
      rdy_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      out_vld_q <= out_vld_d;
      out_typ_q <= out_typ_d;
      out_dat_q <= out_dat_d;
      skd_vld_q <= skd_vld_d;
      skd_typ_q <= skd_typ_d;
      skd_dat_q <= skd_dat_d;
      rdy_q     <= rdy_d;
    end
  end

  assign s_axis_tready = rdy_q;
  assign m_axis_tvalid = out_vld_q;
  assign m_axis_ttype  = out_typ_q;
  assign m_axis_tdata  = out_dat_q;

endmodule

// File: tb/tb_scrambler_64b66b.sv
// Self-checking bench for scrambler_64b66b.
// Bit-serial golden scrambler plus loopback descrambler.
module tb_scrambler_64b66b;

  localparam logic [57:0] SEED = 58'h3FF_FFFF_FFFF_FFFF;
  localparam logic [63:0] ZW   = 64'h03FF_FF80_0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  s_ttype;
  logic [63:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [1:0]  m_ttype;
  logic [63:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
`ifdef SCRAMBLER_BYPASS_EN
  logic        cfg_bypass;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [57:0] mh;
  logic [57:0] dh;
  logic [63:0] eq_d[$];
  logic [1:0]  eq_t[$];
  logic [63:0] pq[$];

  always #5 clk = ~clk;

  scrambler_64b66b #(.SEED(SEED)) dut (
    .clk           (clk),
    .reset         (reset),
`ifdef SCRAMBLER_BYPASS_EN
    .cfg_bypass    (cfg_bypass),
`endif
    .s_axis_ttype  (s_ttype),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_ttype  (m_ttype),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready)
  );

  task automatic model_word(input logic [63:0] d,
                            input logic byp,
                            output logic [63:0] s);
    logic b;
    for (int i = 0; i < 64; i++) begin
      if (byp) s[i] = d[i];
      else begin
        b    = d[i] ^ mh[19] ^ mh[0];
        s[i] = b;
        mh   = {b, mh[57:1]};
      end
    end
  endtask

  task automatic descr(input logic [63:0] s,
                       output logic [63:0] d);
    for (int i = 0; i < 64; i++) begin
      d[i] = s[i] ^ dh[19] ^ dh[0];
      dh   = {s[i], dh[57:1]};
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    s_tdata  = '0;
    s_ttype  = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    mh = SEED;
    eq_d.delete();
    eq_t.delete();
    pq.delete();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++;
    if (m_tvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_tvalid: got %b want 0", m_tvalid);
    end
    n_cmp++;
    if (m_ttype !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_ttype: got %b want 00", m_ttype);
    end
    n_cmp++;
    if (m_tdata !== 64'h0) begin
      n_bad++;
      $display("FAIL rst_tdata: got %h want 0", m_tdata);
    end
    n_cmp++;
    if (s_tready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_tready: got %b want 1", s_tready);
    end
  endtask

  task automatic test_zero_word();
    do_reset();
    m_tready = 1'b1;
    s_tvalid = 1'b1;
    s_ttype  = 2'b01;
    s_tdata  = 64'h0;
    @(posedge clk);
    #1 s_tvalid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (m_tdata !== ZW) begin
      n_bad++;
      $display("FAIL zero_tdata: got %h want %h", m_tdata, ZW);
    end
    n_cmp++;
    if (m_ttype !== 2'b01) begin
      n_bad++;
      $display("FAIL zero_ttype: got %b want 01", m_ttype);
    end
    n_cmp++;
    if (m_tvalid !== 1'b1) begin
      n_bad++;
      $display("FAIL zero_tvalid: got %b want 1", m_tvalid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_stream();
    localparam int N = 1000;
    logic [63:0] sd, dd, ed, pd;
    logic [1:0]  et;
    int got = 0;
    do_reset();
    dh = '0;
    m_tready = 1'b1;
    for (int c = 0; c < N + 3; c++) begin
      s_tvalid = (c < N);
      s_tdata  = {$urandom, $urandom};
      s_ttype  = 2'($urandom);
      @(negedge clk);
      if (m_tvalid && m_tready) begin
        n_cmp++;
        if (eq_d.size() == 0) begin
          n_bad++;
          $display("FAIL stream_extra: got %h want none", m_tdata);
        end else begin
          ed = eq_d.pop_front();
          et = eq_t.pop_front();
          pd = pq.pop_front();
          if (m_tdata !== ed || m_ttype !== et) begin
            n_bad++;
            $display("FAIL stream_word %0d: got %b/%h want %b/%h",
                     got, m_ttype, m_tdata, et, ed);
          end
          descr(m_tdata, dd);
          if (got > 0) begin
            n_cmp++;
            if (dd !== pd) begin
              n_bad++;
              $display("FAIL loopback %0d: got %h want %h",
                       got, dd, pd);
            end
          end
        end
        got++;
      end
      if (s_tvalid && s_tready) begin
        model_word(s_tdata, 1'b0, sd);
        eq_d.push_back(sd);
        eq_t.push_back(s_ttype);
        pq.push_back(s_tdata);
      end
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    n_cmp++;
    if (got != N) begin
      n_bad++;
      $display("FAIL stream_count: got %0d want %0d", got, N);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] sd, ed;
    logic [1:0]  et;
    int acc = 0;
    int bad_rdy = 0;
    int got = 0;
    int gap = 0;
    int maxgap = 0;
    do_reset();
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = {$urandom, $urandom};
    s_ttype  = 2'($urandom);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (acc >= 2 && s_tready) bad_rdy++;
      if (s_tvalid && s_tready) begin
        model_word(s_tdata, 1'b0, sd);
        eq_d.push_back(sd);
        eq_t.push_back(s_ttype);
        acc++;
        @(posedge clk);
        #1;
        s_tdata = {$urandom, $urandom};
        s_ttype = 2'($urandom);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    n_cmp++;
    if (acc != 2) begin
      n_bad++;
      $display("FAIL bp_accepts: got %0d want 2", acc);
    end
    n_cmp++;
    if (bad_rdy != 0) begin
      n_bad++;
      $display("FAIL bp_tready: got %0d high cycles want 0", bad_rdy);
    end
    n_cmp++;
    if (m_tvalid !== 1'b1 || m_tdata !== eq_d[0]) begin
      n_bad++;
      $display("FAIL bp_hold: got %b/%h want 1/%h",
               m_tvalid, m_tdata, eq_d[0]);
    end
    m_tready = 1'b1;
    for (int c = 0; c < 30 && got < 6; c++) begin
      s_tvalid = (acc < 6);
      @(negedge clk);
      if (!m_tvalid) begin
        gap++;
        if (gap > maxgap) maxgap = gap;
      end else gap = 0;
      if (m_tvalid && m_tready) begin
        n_cmp++;
        if (eq_d.size() == 0) begin
          n_bad++;
          $display("FAIL bp_extra: got %h want none", m_tdata);
        end else begin
          ed = eq_d.pop_front();
          et = eq_t.pop_front();
          if (m_tdata !== ed || m_ttype !== et) begin
            n_bad++;
            $display("FAIL bp_word %0d: got %b/%h want %b/%h",
                     got, m_ttype, m_tdata, et, ed);
          end
        end
        got++;
      end
      if (s_tvalid && s_tready) begin
        model_word(s_tdata, 1'b0, sd);
        eq_d.push_back(sd);
        eq_t.push_back(s_ttype);
        acc++;
        @(posedge clk);
        #1;
        s_tdata = {$urandom, $urandom};
        s_ttype = 2'($urandom);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    s_tvalid = 1'b0;
    n_cmp++;
    if (got != 6) begin
      n_bad++;
      $display("FAIL bp_drain: got %0d want 6", got);
    end
    n_cmp++;
    if (maxgap > 1) begin
      n_bad++;
      $display("FAIL bp_gap: got %0d want <=1", maxgap);
    end
  endtask

  task automatic test_random();
    localparam int NR = 3000;
    logic [63:0] sd, ed, pdat;
    logic [1:0]  et, ptyp;
    logic hold = 1'b0;
    logic pstall = 1'b0;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    do_reset();
    while (got < NR && cyc < 40000) begin
      if (!hold) begin
        s_tvalid = (sent < NR) && 1'($urandom_range(0, 1));
        s_tdata  = {$urandom, $urandom};
        s_ttype  = 2'($urandom);
      end
      m_tready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (pstall) begin
        n_cmp++;
        if (m_tvalid !== 1'b1 || m_tdata !== pdat ||
            m_ttype !== ptyp) begin
          n_bad++;
          $display("FAIL rnd_stable: got %b/%h want 1/%h",
                   m_tvalid, m_tdata, pdat);
        end
      end
      if (m_tvalid && m_tready) begin
        n_cmp++;
        if (eq_d.size() == 0) begin
          n_bad++;
          $display("FAIL rnd_extra: got %h want none", m_tdata);
        end else begin
          ed = eq_d.pop_front();
          et = eq_t.pop_front();
          if (m_tdata !== ed || m_ttype !== et) begin
            n_bad++;
            $display("FAIL rnd_word %0d: got %b/%h want %b/%h",
                     got, m_ttype, m_tdata, et, ed);
          end
        end
        got++;
      end
      pstall = m_tvalid && !m_tready;
      pdat   = m_tdata;
      ptyp   = m_ttype;
      if (s_tvalid && s_tready) begin
        model_word(s_tdata, 1'b0, sd);
        eq_d.push_back(sd);
        eq_t.push_back(s_ttype);
        sent++;
        hold = 1'b0;
      end else begin
        hold = s_tvalid;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    s_tvalid = 1'b0;
    n_cmp++;
    if (got != NR) begin
      n_bad++;
      $display("FAIL rnd_timeout: got %0d want %0d", got, NR);
    end
  endtask

  task automatic test_reset_skid();
    do_reset();
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      s_tdata = {$urandom, $urandom};
      s_ttype = 2'b01;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    n_cmp++;
    if (s_tready !== 1'b0) begin
      n_bad++;
      $display("FAIL rs_full: got %b want 0", s_tready);
    end
    @(posedge clk);
    #1;
    reset    = 1'b1;
    s_tvalid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (m_tvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL rs_tvalid: got %b want 0", m_tvalid);
    end
    n_cmp++;
    if (s_tready !== 1'b1) begin
      n_bad++;
      $display("FAIL rs_tready: got %b want 1", s_tready);
    end
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 64'h0;
    s_ttype  = 2'b10;
    @(posedge clk);
    #1 s_tvalid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (m_tdata !== ZW || m_ttype !== 2'b10 || m_tvalid !== 1'b1) begin
      n_bad++;
      $display("FAIL rs_zero: got %b/%b/%h want 1/10/%h",
               m_tvalid, m_ttype, m_tdata, ZW);
    end
    @(posedge clk);
    #1;
  endtask

`ifdef SCRAMBLER_BYPASS_EN
  task automatic test_bypass();
    localparam logic [63:0] A = 64'hDEAD_BEEF_0123_4567;
    do_reset();
    m_tready   = 1'b1;
    cfg_bypass = 1'b1;
    s_tvalid   = 1'b1;
    s_ttype    = 2'b01;
    s_tdata    = A;
    @(posedge clk);
    #1;
    cfg_bypass = 1'b0;
    s_tdata    = 64'h0;
    @(negedge clk);
    n_cmp++;
    if (m_tdata !== A) begin
      n_bad++;
      $display("FAIL byp_pass: got %h want %h", m_tdata, A);
    end
    @(posedge clk);
    #1 s_tvalid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (m_tdata !== ZW) begin
      n_bad++;
      $display("FAIL byp_frozen: got %h want %h", m_tdata, ZW);
    end
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
`ifdef SCRAMBLER_BYPASS_EN
    cfg_bypass = 1'b0;
`endif
    test_reset();
    test_zero_word();
    test_stream();
    test_backpressure();
    test_random();
    test_reset_skid();
`ifdef SCRAMBLER_BYPASS_EN
    test_bypass();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
